// File: rtl/tlp_xcvr_pkg.sv
// tlp_xcvr_pkg: C2F ring geometry, address typedefs and chunk-reader state encoding.
// Shared by the C2F chunk reader and its output buffer; no ports.
package tlp_xcvr_pkg;
  localparam int C2F_NUMCHUNKS = 4;
  localparam int C2F_CHUNKSIZE_NBITS = 7;
  localparam int C2F_SIZE_NBITS = 9;
  localparam int C2F_IDX_W = $clog2(C2F_NUMCHUNKS);
  localparam int C2F_OFF_W = C2F_CHUNKSIZE_NBITS - 3;
  localparam int C2F_ADDR_W = C2F_SIZE_NBITS - 3;
  typedef logic [C2F_IDX_W-1:0] C2FChunkIndex;
  typedef logic [C2F_OFF_W-1:0] C2FChunkOffset;
  typedef logic [C2F_ADDR_W-1:0] C2FAddr;
  typedef logic [63:0] uint64;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } C2FReaderState;
endpackage

// File: rtl/c2f_skid_buf.sv
// c2f_skid_buf: 2-entry {data, last} FIFO feeding the streamed QW output.
// Ports: clk_in/reset_in; push/pushData/pushLast write side (caller guarantees space);
// data_out/last_out/valid_out head entry, ready_in pops; occupancy = entries held.
module c2f_skid_buf
  import tlp_xcvr_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       push,
  input  uint64      pushData,
  input  logic       pushLast,
  input  logic       ready_in,
  output uint64      data_out,
  output logic       last_out,
  output logic       valid_out,
  output logic [1:0] occupancy
);
  uint64 memData [2];
  logic [1:0] memLast;
  logic wrSel, rdSel, pop;
  assign valid_out = occupancy != 2'd0;
  assign pop = valid_out && ready_in;
  assign data_out = memData[rdSel];
  assign last_out = memLast[rdSel];
  always_ff @(posedge clk_in)
    if (reset_in) begin
      memData[0] <= '0;
      memData[1] <= '0;
      memLast <= '0;
      wrSel <= 1'b0;
      rdSel <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        memData[wrSel] <= pushData;
        memLast[wrSel] <= pushLast;
        wrSel <= ~wrSel;
      end
      if (pop) rdSel <= ~rdSel;
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/c2f_chunk_reader.sv
// c2f_chunk_reader: streams completed C2F RAM chunks as a 64-bit valid/ready pipe.
// Ports: clk_in/reset_in; c2fWrPtr_in/c2fRdPtr_in ring pointers; c2fDTAck_out chunk-consumed
// pulse; c2fReadAddr_out/c2fReadData_in RAM read port (1-cycle latency);
// data_out/valid_out/ready_in/last_out output stream.
module c2f_chunk_reader
  import tlp_xcvr_pkg::*;
(
  input  logic         clk_in,
  input  logic         reset_in,
  input  C2FChunkIndex c2fWrPtr_in,
  input  C2FChunkIndex c2fRdPtr_in,
  output logic         c2fDTAck_out,
  output C2FAddr       c2fReadAddr_out,
  input  uint64        c2fReadData_in,
  output uint64        data_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         last_out
);
  C2FReaderState state, nextState;
  C2FChunkOffset rdOff;
  logic [1:0] occupancy;
  logic inFlight, inFlightLast, issue, lastIssue, pop;
  assign pop = valid_out && ready_in;
  // Credit check counts this cycle's pop so a steady 1 QW/cycle flow keeps issuing
  // while the buffer plus the in-flight read never exceed two entries.
  assign issue = state == READ && ({1'b0, occupancy} + {2'b0, inFlight}) < (3'd2 + {2'b0, pop});
  assign lastIssue = issue && rdOff == '1;
  // rdOff is zero outside READ, so this also yields {rdPtr, 0} when idle.
  assign c2fReadAddr_out = {c2fRdPtr_in, rdOff};
  assign c2fDTAck_out = state == ACK;
  always_comb begin
    nextState = state == IDLE  ? (c2fRdPtr_in != c2fWrPtr_in ? READ : IDLE)
              : state == READ  ? (lastIssue ? DRAIN : READ)
              : state == DRAIN ? (pop && last_out ? ACK : DRAIN)
              : IDLE;
  end
  always_ff @(posedge clk_in)
    if (reset_in) begin
      state <= IDLE;
      rdOff <= '0;
      inFlight <= 1'b0;
      inFlightLast <= 1'b0;
    end else begin
      state <= nextState;
      if (issue) rdOff <= rdOff + C2FChunkOffset'(1);
      inFlight <= issue;
      inFlightLast <= lastIssue;
    end
  c2f_skid_buf u_buf (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .push      (inFlight),
    .pushData  (c2fReadData_in),
    .pushLast  (inFlightLast),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .last_out  (last_out),
    .valid_out (valid_out),
    .occupancy (occupancy)
  );
endmodule

// File: doc/c2f_chunk_reader.md
# c2f_chunk_reader

FPGA-side consumer of the CPU→FPGA burst pipe. The host fills chunks of the C2F RAM through `tlp_xcvr`, then advances `C2F_WRPTR`. This block reads each completed chunk out of the RAM's read port and streams it as a 64-bit valid/ready pipe. When the chunk is fully consumed it pulses `c2fDTAck`, so `tlp_xcvr` can advance `c2fRdPtr` and free the chunk for the host.

## Interface
Parameters (all taken from `tlp_xcvr_pkg`, not overridable per instance):
- `C2F_NUMCHUNKS`, default 4: chunks in the C2F ring; chunk index is 2 bits.
- `C2F_CHUNKSIZE_NBITS`, default 7: 128-byte chunk, 16 QWs, 4-bit `C2FChunkOffset`.
- `C2F_SIZE_NBITS`, default 9: 512-byte RAM; `C2FAddr` = {index, offset} is 6 bits.

Ports:
- `clk_in`  in  1  system clock; everything is synchronous to it.
- `reset_in`  in  1  synchronous, active-high reset.
- `c2fWrPtr_in`  in  `C2FChunkIndex`  host write pointer, from `tlp_xcvr`.
- `c2fRdPtr_in`  in  `C2FChunkIndex`  read pointer, owned by `tlp_xcvr`; increments on the edge where `c2fDTAck_out` is high.
- `c2fDTAck_out`  out  1  one-cycle pulse: chunk `c2fRdPtr_in` fully consumed.
- `c2fReadAddr_out`  out  `C2FAddr`  RAM read address.
- `c2fReadData_in`  in  `uint64`  RAM read data; registered, valid 1 cycle after the address.
- `data_out`  out  `uint64`  streamed QW.
- `valid_out`  out  1  `data_out` valid.
- `ready_in`  in  1  sink accepts when `valid_out && ready_in`.
- `last_out`  out  1  high with the final QW (offset 15) of a chunk.

## Operation
- Ring is empty when `c2fRdPtr_in == c2fWrPtr_in`. `tlp_xcvr` guarantees the host never fills the ring to equality, so any inequality means at least one chunk is ready.
- States:
  - IDLE: `c2fReadAddr_out` = {`c2fRdPtr_in`, 0}. Go to READ when the pointers differ.
  - READ: on each issue, `c2fReadAddr_out` = {`c2fRdPtr_in`, rdOff}. A read is issued in a cycle only if buffer occupancy + in-flight reads < 2; rdOff increments per issue. After offset 15 is issued, go to DRAIN.
  - DRAIN: wait until the QW with `last_out` is accepted, then go to ACK.
  - ACK: `c2fDTAck_out` = 1 for exactly one cycle, then IDLE.
- Output buffer holds 2 entries of {data, last}. `data_out`, `last_out` and `valid_out` come from its head entry. Each read result is captured the cycle after issue.
- A QW is never dropped, duplicated or reordered. While `valid_out` is high and `ready_in` is low, `data_out` and `last_out` hold stable.
- rdOff is 4 bits and wraps 15→0. Chunk index wraps `C2F_NUMCHUNKS-1`→0 through `tlp_xcvr`, so the pointer comparison needs no special handling.
- `c2fWrPtr_in` changing mid-chunk does not affect the chunk in progress.
- Reset, at any time including mid-chunk:
  - state → IDLE, rdOff = 0, buffer emptied, in-flight read discarded.
  - Outputs: `valid_out` = 0, `last_out` = 0, `c2fDTAck_out` = 0, `data_out` = 0, `c2fReadAddr_out` = {`c2fRdPtr_in`, 0}.
  - No ack was sent, so a partially streamed chunk is re-streamed from offset 0.

## Timing
- Cycle T: IDLE with the pointers differing.
  - T+1: READ, address offset 0.
  - T+2: RAM data.
  - T+3: first `valid_out`.
- With `ready_in` held high the block sustains 1 QW per cycle: QWs at T+3..T+18, `last_out` at T+18, `c2fDTAck_out` at T+19, IDLE at T+20.
- Back-to-back chunks: the next chunk's first QW is at T+23, leaving a 4-cycle bubble.
- Backpressure: `ready_in` low for N cycles stalls output by exactly N cycles. At most 2 QWs are buffered plus 0 in flight.

## Structure
- `tlp_xcvr_pkg` owns:
  - constants `C2F_NUMCHUNKS`, `C2F_CHUNKSIZE_NBITS`, `C2F_SIZE_NBITS`;
  - typedefs `C2FChunkIndex`, `C2FChunkOffset`, `C2FAddr`, `uint64`;
  - a `C2FReaderState` enum {IDLE, READ, DRAIN, ACK}.
- One sub-module: `c2f_skid_buf`, the 2-entry {uint64, last} FIFO with valid/ready and an occupancy output used by the issue logic.

## Test plan
- Reset: hold `reset_in` for 4 cycles → `valid_out`, `last_out`, `c2fDTAck_out` = 0 and `c2fReadAddr_out` = 0.
- Single chunk: preload chunk 0 with `SEQ64[0..15]`, move `c2fWrPtr_in` 0→1, `ready_in` = 1.
  - Expect `SEQ64[0..15]` on consecutive cycles from T+3, with `last_out` only on the 16th.
  - Expect exactly one `c2fDTAck_out` pulse; the model's rdPtr becomes 1 and the block returns to idle.
- Backpressure: as the single-chunk case, with `ready_in` toggling 1,0 and then held low for 10 cycles after QW 5.
  - Expect the accepted sequence to equal `SEQ64[0..15]` exactly.
  - Expect `data_out` stable while stalled.
- Back-to-back: chunks 0–2 loaded with `SEQ64[0..47]`, `c2fWrPtr_in` 0→3.
  - Expect 48 QWs in order and three DTAck pulses.
  - Expect a 4-cycle gap between chunks, then idle with the pointers equal.
- Wrap: rdPtr = 3, load chunk 3, `c2fWrPtr_in` 3→0.
  - Expect read addresses 48..63, then DTAck; rdPtr wraps to 0 and the block goes idle.
- Mid-chunk reset: assert `reset_in` for 1 cycle after 5 QWs are accepted from chunk 0.
  - Expect no DTAck; streaming restarts with `SEQ64[0]` at the offset-0 restart.
